// File: rtl/md5_crack_scheduler.sv
// Brute-force guess sequencer feeding one MD5 pipeline and watching its digests for the target.
// Optional MD5_SCHED_EARLY_STOP_EN: the first match ends the search instead of exhausting the space.
module md5_crack_scheduler #(
    parameter int         LATENCY  = 34,
    parameter logic [7:0] CHAR_MIN = 8'h61,
    parameter logic [7:0] CHAR_MAX = 8'h7a,
    parameter int         MAX_LEN  = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   cfg_len,
    input  logic [127:0] cfg_target,
    output logic [127:0] guess,
    output logic [3:0]   guesslen,
    input  logic [31:0]  hashA,
    input  logic [31:0]  hashB,
    input  logic [31:0]  hashC,
    input  logic [31:0]  hashD,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         found,
    output logic [127:0] found_guess,
    output logic [39:0]  guess_count
);

`ifdef MD5_SCHED_EARLY_STOP_EN
    localparam bit EARLY_STOP = 1'b1;
`else
    localparam bit EARLY_STOP = 1'b0;
`endif

    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q;
    logic [127:0]       guess_q;
    logic [3:0]         guesslen_q;
    logic [3:0]         len_q;
    logic [127:0]       target_q;
    logic               busy_q, done_q, err_q, found_q;
    logic [127:0]       found_guess_q;
    logic [39:0]        count_q;
    logic [CNT_W-1:0]   drain_cnt_q;
    logic [LATENCY-1:0] dl_vld_q;
    logic [127:0]       dl_gss_q [LATENCY];

    logic [128:0]       inc_d;
    logic               hit_d;
    logic               stop_d;
    logic               len_ok_d;

    function automatic logic [127:0] first_guess(input logic [3:0] len);
        logic [127:0] g;
        g = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(len)) g[8*(15-i) +: 8] = CHAR_MIN;
        end
        return g;
    endfunction

    // Odometer step: byte len-1 moves fastest; the top bit is the carry out of byte 0.
    function automatic logic [128:0] next_guess(input logic [127:0] g, input logic [3:0] len);
        logic [127:0] n;
        logic         c;
        n = g;
        c = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            if (c && (i < int'(len))) begin
                if (n[8*(15-i) +: 8] == CHAR_MAX) begin
                    n[8*(15-i) +: 8] = CHAR_MIN;
                end else begin
                    n[8*(15-i) +: 8] = n[8*(15-i) +: 8] + 8'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, n};
    endfunction

    assign inc_d    = next_guess(guess_q, len_q);
    assign hit_d    = dl_vld_q[LATENCY-1] && ({hashA, hashB, hashC, hashD} == target_q);
    assign stop_d   = EARLY_STOP && hit_d && !found_q;
    assign len_ok_d = (cfg_len != 4'd0) && (int'(cfg_len) <= MAX_LEN);

    // Delay-line payload carries no reset; only the valids gate matching.
    always_ff @(posedge clk) begin
        dl_gss_q[0] <= guess_q;
        for (int i = 1; i < LATENCY; i++) dl_gss_q[i] <= dl_gss_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst || stop_d) dl_vld_q <= '0;
        else               dl_vld_q <= {dl_vld_q[LATENCY-2:0], state_q == S_RUN};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            guess_q       <= '0;
            guesslen_q    <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            found_q       <= 1'b0;
            found_guess_q <= '0;
            count_q       <= '0;
            drain_cnt_q   <= '0;
        end else begin
            if (hit_d) begin
                found_q <= 1'b1;
                if (!found_q) found_guess_q <= dl_gss_q[LATENCY-1];
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        found_q       <= 1'b0;
                        found_guess_q <= '0;
                        count_q       <= '0;
                        len_q         <= cfg_len;
                        target_q      <= cfg_target;
                        if (len_ok_d) begin
                            state_q    <= S_RUN;
                            busy_q     <= 1'b1;
                            done_q     <= 1'b0;
                            err_q      <= 1'b0;
                            guess_q    <= first_guess(cfg_len);
                            guesslen_q <= cfg_len;
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    count_q <= count_q + 40'd1;
                    if (stop_d || inc_d[128]) begin
                        state_q     <= S_DRAIN;
                        guess_q     <= '0;
                        guesslen_q  <= '0;
                        drain_cnt_q <= stop_d ? '0 : CNT_W'(LATENCY - 1);
                    end else begin
                        guess_q <= inc_d[127:0];
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt_q == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (stop_d) begin
                        drain_cnt_q <= '0;
                    end else begin
                        drain_cnt_q <= drain_cnt_q - 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign guess       = guess_q;
    assign guesslen    = guesslen_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign found       = found_q;
    assign found_guess = found_guess_q;
    assign guess_count = count_q;

endmodule

// File: tb/tb_md5_crack_scheduler.sv
// Directed bench for md5_crack_scheduler with an identity hash stub (digest = guess delayed LATENCY).
module tb_md5_crack_scheduler;
    localparam int LAT = 34;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   cfg_len;
    logic [127:0] cfg_target;
    logic [127:0] guess;
    logic [3:0]   guesslen;
    logic [31:0]  hashA, hashB, hashC, hashD;
    logic         busy, done, err, found;
    logic [127:0] found_guess;
    logic [39:0]  guess_count;

    logic [127:0] pipe [LAT];

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] AA   = {8'h61, 8'h61, 112'h0};
    localparam logic [127:0] AB   = {8'h61, 8'h62, 112'h0};
    localparam logic [127:0] ZZ   = {8'h7a, 8'h7a, 112'h0};
    localparam logic [127:0] Z1   = {8'h7a, 120'h0};
    localparam logic [127:0] C1   = {8'h63, 120'h0};
    localparam logic [127:0] AAB  = {24'h616162, 104'h0};
    localparam logic [127:0] ZZZ  = {24'h7a7a7a, 104'h0};
    localparam logic [127:0] ONES = {128{1'b1}};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pipe[0] <= guess;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign {hashA, hashB, hashC, hashD} = pipe[LAT-1];

    md5_crack_scheduler #(.LATENCY(LAT), .CHAR_MIN(8'h61), .CHAR_MAX(8'h7a), .MAX_LEN(8)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len), .cfg_target(cfg_target),
        .guess(guess), .guesslen(guesslen),
        .hashA(hashA), .hashB(hashB), .hashC(hashC), .hashD(hashD),
        .busy(busy), .done(done), .err(err), .found(found),
        .found_guess(found_guess), .guess_count(guess_count)
    );

    task automatic do_start(input logic [3:0] len, input logic [127:0] tgt);
        @(negedge clk);
        start = 1'b1; cfg_len = len; cfg_target = tgt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; cfg_len = 4'd0; cfg_target = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); errors++; end
        checks++; if (done !== 1'b0) begin $display("FAIL reset_done got %b want 0", done); errors++; end
        checks++; if (err !== 1'b0) begin $display("FAIL reset_err got %b want 0", err); errors++; end
        checks++; if (found !== 1'b0) begin $display("FAIL reset_found got %b want 0", found); errors++; end
        checks++; if (guess !== 128'h0) begin $display("FAIL reset_guess got %h want 0", guess); errors++; end
        checks++; if (guesslen !== 4'd0) begin $display("FAIL reset_guesslen got %0d want 0", guesslen); errors++; end
        checks++; if (found_guess !== 128'h0) begin $display("FAIL reset_fguess got %h want 0", found_guess); errors++; end
        checks++; if (guess_count !== 40'd0) begin $display("FAIL reset_count got %0d want 0", guess_count); errors++; end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin $display("FAIL idle_hold busy=%b done=%b want 0 0", busy, done); errors++; end
    endtask

    task automatic test_first_hit;
        do_start(4'd2, AB);
        checks++; if (guess !== AA) begin $display("FAIL hit_first_guess got %h want %h", guess, AA); errors++; end
        checks++; if (busy !== 1'b1 || guesslen !== 4'd2) begin $display("FAIL hit_run busy=%b len=%0d want 1 2", busy, guesslen); errors++; end
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (guess !== AB) begin $display("FAIL hit_second_guess got %h want %h", guess, AB); errors++; end
            end
            if (k == LAT + 1) begin
                checks++; if (found !== 1'b0) begin $display("FAIL hit_found_early got %b want 0", found); errors++; end
            end
            if (k == LAT + 2) begin
                checks++; if (found !== 1'b1) begin $display("FAIL hit_found got %b want 1", found); errors++; end
                checks++; if (found_guess !== AB) begin $display("FAIL hit_fguess got %h want %h", found_guess, AB); errors++; end
            end
`ifdef MD5_SCHED_EARLY_STOP_EN
            if (k == LAT + 2) begin
                checks++; if (guess !== 128'h0 || done !== 1'b0) begin $display("FAIL stop_issue guess=%h done=%b want 0 0", guess, done); errors++; end
            end
            if (k == LAT + 3) begin
                checks++; if (done !== 1'b1 || busy !== 1'b0) begin $display("FAIL stop_done done=%b busy=%b want 1 0", done, busy); errors++; end
                checks++; if (guess_count !== 40'(2 + LAT)) begin $display("FAIL stop_count got %0d want %0d", guess_count, 2 + LAT); errors++; end
                break;
            end
`else
            if (k == 675) begin
                checks++; if (guess !== ZZ) begin $display("FAIL hit_last_guess got %h want %h", guess, ZZ); errors++; end
            end
            if (k == 675 + LAT) begin
                checks++; if (done !== 1'b0 || busy !== 1'b1) begin $display("FAIL hit_drain done=%b busy=%b want 0 1", done, busy); errors++; end
            end
            if (k == 676 + LAT) begin
                checks++; if (done !== 1'b1 || busy !== 1'b0) begin $display("FAIL hit_done done=%b busy=%b want 1 0", done, busy); errors++; end
                checks++; if (guess_count !== 40'd676) begin $display("FAIL hit_count got %0d want 676", guess_count); errors++; end
                checks++; if (found_guess !== AB) begin $display("FAIL hit_fguess_end got %h want %h", found_guess, AB); errors++; end
                break;
            end
`endif
            if (k == 800) begin
                checks++; errors++; $display("FAIL hit_timeout done=%b want 1", done);
            end
        end
    endtask

    task automatic test_last_guess;
        do_start(4'd1, Z1);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 25) begin
                checks++; if (guess !== Z1) begin $display("FAIL last_guess got %h want %h", guess, Z1); errors++; end
            end
            if (k == 25 + LAT) begin
                checks++; if (found !== 1'b0 || done !== 1'b0) begin $display("FAIL last_drain found=%b done=%b want 0 0", found, done); errors++; end
            end
            if (k == 26 + LAT) begin
                checks++; if (found !== 1'b1 || done !== 1'b1) begin $display("FAIL last_done found=%b done=%b want 1 1", found, done); errors++; end
                checks++; if (guess_count !== 40'd26) begin $display("FAIL last_count got %0d want 26", guess_count); errors++; end
                checks++; if (found_guess !== Z1) begin $display("FAIL last_fguess got %h want %h", found_guess, Z1); errors++; end
                break;
            end
            if (k == 200) begin
                checks++; errors++; $display("FAIL last_timeout done=%b want 1", done);
            end
        end
    endtask

    task automatic test_bad_len;
        logic [3:0] lens [2];
        lens[0] = 4'd0; lens[1] = 4'd9;
        for (int j = 0; j < 2; j++) begin
            do_start(lens[j], AB);
            checks++; if (done !== 1'b1 || err !== 1'b1) begin $display("FAIL badlen%0d done=%b err=%b want 1 1", j, done, err); errors++; end
            checks++; if (busy !== 1'b0 || guess_count !== 40'd0) begin $display("FAIL badlen%0d_busy busy=%b count=%0d want 0 0", j, busy, guess_count); errors++; end
            @(negedge clk);
            checks++; if (busy !== 1'b0 || guess !== 128'h0) begin $display("FAIL badlen%0d_hold busy=%b guess=%h want 0 0", j, busy, guess); errors++; end
        end
    endtask

    task automatic test_no_hit;
        do_start(4'd3, ONES);
        for (int k = 1; k <= 17700; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (guess !== AAB) begin $display("FAIL nohit_second got %h want %h", guess, AAB); errors++; end
            end
            if (k == 100) begin start = 1'b1; cfg_len = 4'd1; end
            if (k == 101) begin start = 1'b0; cfg_len = 4'd3; end
            if (k == 17575) begin
                checks++; if (guess !== ZZZ) begin $display("FAIL nohit_last got %h want %h", guess, ZZZ); errors++; end
            end
            if (k == 17576 + LAT) begin
                checks++; if (done !== 1'b1 || err !== 1'b0 || found !== 1'b0) begin $display("FAIL nohit_done done=%b err=%b found=%b want 1 0 0", done, err, found); errors++; end
                checks++; if (guess_count !== 40'd17576) begin $display("FAIL nohit_count got %0d want 17576", guess_count); errors++; end
                break;
            end
            if (k == 17700) begin
                checks++; errors++; $display("FAIL nohit_timeout done=%b want 1", done);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        logic stray;
        do_start(4'd2, AB);
        repeat (LAT) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || found !== 1'b0) begin
            $display("FAIL midrst_ctrl busy=%b done=%b err=%b found=%b want 0 0 0 0", busy, done, err, found); errors++; end
        checks++; if (guess !== 128'h0 || guesslen !== 4'd0 || guess_count !== 40'd0 || found_guess !== 128'h0) begin
            $display("FAIL midrst_data guess=%h len=%0d count=%0d fguess=%h want 0", guess, guesslen, guess_count, found_guess); errors++; end
        stray = 1'b0;
        repeat (LAT + 5) begin
            @(negedge clk);
            if (found !== 1'b0) stray = 1'b1;
        end
        checks++; if (stray !== 1'b0) begin $display("FAIL midrst_stale found=%b want 0", stray); errors++; end
        do_start(4'd1, C1);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 26 + LAT) begin
                checks++; if (done !== 1'b1 || found !== 1'b1) begin $display("FAIL rerun_done done=%b found=%b want 1 1", done, found); errors++; end
                checks++; if (found_guess !== C1 || guess_count !== 40'd26) begin $display("FAIL rerun_result fguess=%h count=%0d want %h 26", found_guess, guess_count, C1); errors++; end
                break;
            end
            if (k == 200) begin
                checks++; errors++; $display("FAIL rerun_timeout done=%b want 1", done);
            end
        end
    endtask

    initial begin
        test_reset;
        test_first_hit;
        test_last_guess;
        test_bad_len;
        test_no_hit;
        test_reset_mid_run;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
